// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- buffered UART transmitter.
//
// Bytes written through a strobe are queued in a small circular FIFO. They
// are then sent on uart_txd as frames: a start bit, PAYLOAD_BITS data bits
// LSB first, and STOP_BITS stop bits.
//
// Ports:
//   clk       system clock; every register updates on its rising edge
//   resetn    asynchronous, active-low reset
//   wr_en     write strobe; a byte is taken when wr_en=1 and full=0
//   wr_data   byte to enqueue
//   full      FIFO holds FIFO_DEPTH entries (registered)
//   empty     FIFO holds no entries (registered)
//   level     current FIFO occupancy (registered)
//   overflow  one-cycle pulse after a write that was refused because full=1
//   tx_busy   a frame is in progress or the FIFO is non-empty
//   uart_txd  serial line, driven straight from a register
module uart_tx_fifo #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_en,
  input  logic [PAYLOAD_BITS-1:0]       wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          tx_busy,
  output logic                          uart_txd
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int STOP_CYCLES    = STOP_BITS * CYCLES_PER_BIT;
  // One counter times every bit, so it is sized for the longest period,
  // which is the stop interval when STOP_BITS is 2.
  localparam int CNT_W = $clog2(STOP_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int IDX_W = $clog2(PAYLOAD_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage: no reset, so it can map onto plain RAM.
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [LVL_W-1:0]        level_reg;
  logic [LVL_W-1:0]        level_next;
  logic                    full_reg;
  logic                    empty_reg;
  logic                    overflow_reg;

  state_t                  state_reg;
  logic [PAYLOAD_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    txd_reg;
  logic                    tx_busy_reg;

  logic push;
  logic pop;
  logic bit_done;
  logic stop_done;
  logic frame_end;
  logic busy_next;

  always_comb begin
    // Fullness comes only from the registered flag. A write made while full
    // is refused even if a pop frees a slot on the same edge.
    push      = wr_en && !full_reg;
    bit_done  = (cnt_reg == BIT_LAST);
    stop_done = (cnt_reg == STOP_LAST);
    frame_end = (state_reg == STOP) && stop_done;
    // Pop from IDLE, or at the last stop cycle so frames run back to back.
    pop       = !empty_reg && ((state_reg == IDLE) || frame_end);

    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = level_reg - LVL_W'(1);
    end

    busy_next = (level_next != '0) || pop || ((state_reg != IDLE) && !frame_end);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // FIFO bookkeeping. full, empty and level all come from the same
  // level_next, so they always agree.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      level_reg    <= level_next;
      full_reg     <= (level_next == DEPTH_LVL);
      empty_reg    <= (level_next == '0);
      overflow_reg <= wr_en && full_reg;
    end
  end

  // Transmit FSM. The line value for the next bit is loaded on the same edge
  // that starts that bit, so every bit lasts exactly CYCLES_PER_BIT cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      txd_reg     <= 1'b1;
      tx_busy_reg <= 1'b0;
    end else begin
      tx_busy_reg <= busy_next;
      case (state_reg)
        IDLE: begin
          txd_reg <= 1'b1;
          if (pop) begin
            state_reg <= START;
            shift_reg <= mem[rd_ptr_reg];
            cnt_reg   <= '0;
            txd_reg   <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state_reg <= DATA;
            txd_reg   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            idx_reg   <= '0;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_reg <= '0;
            if (idx_reg == IDX_LAST) begin
              state_reg <= STOP;
              txd_reg   <= 1'b1;
            end else begin
              txd_reg   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              idx_reg   <= idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        STOP: begin
          if (stop_done) begin
            cnt_reg <= '0;
            if (pop) begin
              state_reg <= START;
              shift_reg <= mem[rd_ptr_reg];
              txd_reg   <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          txd_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign full     = full_reg;
  assign empty    = empty_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign tx_busy  = tx_busy_reg;
  assign uart_txd = txd_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int C     = 4;            // 40 Hz / 10 bit/s
  localparam int D     = 4;
  localparam int FRAME = (1 + 8 + 1) * C;
  localparam int DEF_C = 50000000 / 9600;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Fast instance (scenarios 1-5 and random traffic)
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       full, empty, overflow, tx_busy, txd;
  logic [2:0] level;

  // Default-parameter instance (scenario 6)
  logic       wr_en_d = 1'b0;
  logic [7:0] wr_data_d = '0;
  logic       full_d, empty_d, overflow_d, tx_busy_d, txd_d;
  logic [3:0] level_d;

  uart_tx_fifo #(.CLK_HZ(40), .BIT_RATE(10), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .tx_busy(tx_busy), .uart_txd(txd)
  );

  uart_tx_fifo dut_def (
    .clk(clk), .resetn(resetn), .wr_en(wr_en_d), .wr_data(wr_data_d),
    .full(full_d), .empty(empty_d), .level(level_d), .overflow(overflow_d),
    .tx_busy(tx_busy_d), .uart_txd(txd_d)
  );

  int errors = 0;
  int checks = 0;
  int rst_count = 0;
  bit chk_en = 1'b0;

  // Reference model: a queue of pending bytes plus a countdown of the
  // cycles left in the frame currently on the line.
  logic [7:0] q_model[$];
  logic [7:0] sb_q[$];
  logic [7:0] sb_def[$];
  int         busy_left = 0;
  logic [7:0] cur_byte = '0;
  logic       m_ovf = 1'b0;
  int         m_pre;
  bit         m_pop;

  task automatic check_eq(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge resetn) rst_count++;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_model.delete();
      sb_q.delete();
      busy_left = 0;
      m_ovf = 1'b0;
    end else begin
      m_pre = q_model.size();
      m_pop = (m_pre > 0) && (busy_left <= 1);
      m_ovf = wr_en && (m_pre == D);
      if (busy_left > 0) busy_left--;
      if (m_pop) begin
        cur_byte = q_model.pop_front();
        sb_q.push_back(cur_byte);
        busy_left = FRAME;
      end
      if (wr_en && (m_pre < D)) q_model.push_back(wr_data);
    end
  end

  function automatic logic exp_txd();
    int pos, bi;
    if (busy_left == 0) return 1'b1;
    pos = FRAME - busy_left;
    bi = pos / C;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return cur_byte[bi-1];
    return 1'b1;
  endfunction

  // Cycle-by-cycle comparison of the fast instance against the model
  always @(posedge clk) begin
    logic e_txd, e_full, e_empty, e_busy;
    int   e_lvl;
    #1;
    if (chk_en) begin
      e_txd   = exp_txd();
      e_lvl   = q_model.size();
      e_full  = (e_lvl == D);
      e_empty = (e_lvl == 0);
      e_busy  = (busy_left > 0) || (e_lvl > 0);
      checks++;
      if ({txd, full, empty, overflow, tx_busy} !== {e_txd, e_full, e_empty, m_ovf, e_busy}
          || int'(level) != e_lvl) begin
        errors++;
        $display("FAIL cycle_check t=%0t: got txd=%b lvl=%0d full=%b empty=%b ovf=%b busy=%b, expected txd=%b lvl=%0d full=%b empty=%b ovf=%b busy=%b",
                 $time, txd, level, full, empty, overflow, tx_busy,
                 e_txd, e_lvl, e_full, e_empty, m_ovf, e_busy);
      end
    end
  end

  function automatic logic line(input int which);
    return (which == 0) ? txd : txd_d;
  endfunction

  // Receiver monitor: detects a start bit, samples mid-bit, pops the
  // scoreboard and compares. Frames cut short by reset are discarded.
  task automatic rx_monitor(input int which, input int cpb);
    logic [7:0] b, e;
    logic s0, s1;
    int gen;
    forever begin
      @(posedge clk); #2;
      if (resetn && line(which) == 1'b0) begin
        gen = rst_count;
        repeat (cpb / 2) @(posedge clk);
        #2;
        s0 = line(which);
        for (int i = 0; i < 8; i++) begin
          repeat (cpb) @(posedge clk);
          #2;
          b[i] = line(which);
        end
        repeat (cpb) @(posedge clk);
        #2;
        s1 = line(which);
        if (gen == rst_count && resetn) begin
          checks++;
          if ((which == 0 && sb_q.size() == 0) || (which == 1 && sb_def.size() == 0)) begin
            errors++;
            $display("FAIL rx_unexpected[%0d]: got byte %02h, expected no frame", which, b);
          end else begin
            e = (which == 0) ? sb_q.pop_front() : sb_def.pop_front();
            if (b !== e || s0 !== 1'b0 || s1 !== 1'b1) begin
              errors++;
              $display("FAIL rx_frame[%0d]: got byte %02h start=%b stop=%b, expected byte %02h start=0 stop=1",
                       which, b, s0, s1, e);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((tx_busy !== 1'b0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(name, tx_busy, 0);
  endtask

  initial begin
    int n, e, bad, run, p;
    logic cur;
    logic [7:0] a5;

    fork
      rx_monitor(0, C);
      rx_monitor(1, DEF_C);
    join_none

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;

    // 1: idle after reset
    check_eq("reset_txd", txd, 1);
    check_eq("reset_level", level, 0);
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || empty !== 1'b1 || level != 0 || tx_busy !== 1'b0) bad++;
    end
    check_eq("idle_100_cycles_bad", bad, 0);

    // 2: single byte 0xA5
    a5 = 8'hA5;
    @(negedge clk);
    wr_en = 1'b1; wr_data = a5;
    @(posedge clk); #1;
    check_eq("a5_level_after_e0", level, 1);
    check_eq("a5_empty_after_e0", empty, 0);
    check_eq("a5_busy_after_e0", tx_busy, 1);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    check_eq("a5_start_after_e1", txd, 0);
    check_eq("a5_level_after_pop", level, 0);
    bad = 0;
    for (int k = 1; k < FRAME; k++) begin
      @(posedge clk); #1;
      if (k < C) begin
        if (txd !== 1'b0) bad++;
      end else if (k < 9 * C) begin
        if (txd !== a5[(k - C) / C]) bad++;
      end else begin
        if (txd !== 1'b1) bad++;
      end
    end
    check_eq("a5_frame_bits_bad", bad, 0);
    @(posedge clk); #1;
    check_eq("a5_busy_fall", tx_busy, 0);

    // 3: burst of 5 plus a refused 6th
    e = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'(i);
      @(posedge clk); #1;
      e++;
      if (i == 5) begin
        check_eq("burst_full_after_5", full, 1);
        check_eq("burst_level_after_5", level, 4);
      end
      if (i == 6) begin
        check_eq("burst_overflow_6th", overflow, 1);
        check_eq("burst_level_after_6", level, 4);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    e++;
    check_eq("burst_overflow_one_cycle", overflow, 0);
    while (tx_busy === 1'b1 && e < 600) begin
      @(posedge clk); #1;
      e++;
    end
    check_eq("burst_busy_edges", e, 2 + 5 * FRAME);

    // 4: write while full, on the same edge as a pop
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (!(busy_left == 1 && q_model.size() == D) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("s4_full_before", full, 1);
    wr_en = 1'b1; wr_data = 8'hEE;
    @(posedge clk); #1;
    check_eq("s4_overflow", overflow, 1);
    check_eq("s4_level_dropped", level, 3);
    check_eq("s4_full_cleared", full, 0);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    check_eq("s4_overflow_one_cycle", overflow, 0);
    wait_idle("s4_drain");

    // 5: reset during bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = (i == 0) ? 8'h30 : 8'h11 * 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (busy_left != FRAME - 17 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("s5_level_before", level, 2);
    check_eq("s5_bit3_low", txd, 0);
    resetn = 1'b0;
    #1;
    check_eq("s5_async_txd", txd, 1);
    check_eq("s5_async_level", level, 0);
    check_eq("s5_async_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || tx_busy !== 1'b0 || level != 0) bad++;
    end
    check_eq("s5_no_frames_after", bad, 0);

    // Random traffic with varying write density
    for (int w = 0; w < 6; w++) begin
      p = (w % 3 == 0) ? 4 : ((w % 3 == 1) ? 20 : 60);
      repeat (500) begin
        @(negedge clk);
        wr_en = ($urandom_range(0, 99) < p);
        wr_data = 8'($urandom);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle("random_drain");
    repeat (5) @(posedge clk);
    check_eq("random_sb_empty", sb_q.size(), 0);

    // 6: default parameters, 0x55
    @(negedge clk);
    wr_en_d = 1'b1; wr_data_d = 8'h55;
    sb_def.push_back(8'h55);
    n = 0;
    @(posedge clk); #1;
    n++;
    @(negedge clk);
    wr_en_d = 1'b0;
    while (txd_d !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("def_start_latency", n, 2);
    cur = 1'b0;
    for (int k = 0; k < 9; k++) begin
      run = 1;
      @(posedge clk); #1;
      while (txd_d === cur && run < 6000) begin
        run++;
        @(posedge clk); #1;
      end
      check_eq($sformatf("def_bit%0d_len", k), run, DEF_C);
      cur = ~cur;
    end
    check_eq("def_stop_level", txd_d, 1);
    run = 1;
    @(posedge clk); #1;
    while (tx_busy_d === 1'b1 && run < 6000) begin
      run++;
      @(posedge clk); #1;
    end
    check_eq("def_stop_len", run, DEF_C);
    repeat (5) @(posedge clk);
    check_eq("def_sb_empty", sb_def.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
